// File: rtl/insr_issue_ctrl_if.sv
// Bundle for the fetch/issue controller: instruction-memory request side, execute handoff and status.
// master = controller side, slave = memory/execute/observer side.
interface insr_issue_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] insr;
    logic        insr_valid;
    logic        ex_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [1:0]  state;
    logic        trap;

    modport master (
        output imem_req, imem_addr, insr, insr_valid, pc, state, trap,
        input  imem_ack, imem_data, ex_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, insr, insr_valid, pc, state, trap,
        output imem_ack, imem_data, ex_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/insr_issue_ctrl.sv
// Fetch/issue sequencer: requests a word at pc, holds it for execute; ILLEGAL_TRAP_EN adds an illegal-opcode HALT.
// Latency: insr_valid rises the cycle after imem_ack; pc advances the cycle after insr_valid & ex_ready.
// Backpressure: insr/pc held while ex_ready=0; request drops for one cycle after MEM_TIMEOUT idle fetch cycles.
module insr_issue_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic               clk,
    input logic               rst,
    insr_issue_ctrl_if.master bus
);
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [7:0]  TMO_LIMIT = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1
`ifdef ILLEGAL_TRAP_EN
        ,
        HALT  = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] insr_q, insr_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        fetch_gap;
    logic        req;
    logic        ack_take;
    logic [31:0] redirect_aligned;

    // The gap cycle is the one where the counter has reached the limit; an ack
    // there is not paired with an outstanding request and is ignored.
    assign fetch_gap        = (state_q == FETCH) && (tmo_q == TMO_LIMIT);
    assign req              = (state_q == FETCH) && !fetch_gap;
    assign ack_take         = req && bus.imem_ack;
    assign redirect_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef ILLEGAL_TRAP_EN
    logic opcode_ok;
    always_comb begin
        case (bus.imem_data[6:0])
            7'b0110011, 7'b0010011, 7'b0000011,
            7'b0100011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: opcode_ok = 1'b1;
            default:                            opcode_ok = 1'b0;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        insr_d  = insr_q;
        tmo_d   = tmo_q;
        case (state_q)
            FETCH: begin
                if (bus.redirect) begin
                    pc_d  = redirect_aligned;
                    tmo_d = 8'd0;
                end else if (ack_take) begin
                    insr_d = bus.imem_data;
                    tmo_d  = 8'd0;
`ifdef ILLEGAL_TRAP_EN
                    state_d = opcode_ok ? ISSUE : HALT;
`else
                    state_d = ISSUE;
`endif
                end else if (fetch_gap) begin
                    tmo_d = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ISSUE: begin
                if (bus.redirect) begin
                    pc_d    = redirect_aligned;
                    tmo_d   = 8'd0;
                    state_d = FETCH;
                end else if (bus.ex_ready) begin
                    pc_d    = pc_q + 32'd4;
                    tmo_d   = 8'd0;
                    state_d = FETCH;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = FETCH;
                tmo_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            insr_q  <= NOP_WORD;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insr_q  <= insr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc_q;
    assign bus.pc         = pc_q;
    assign bus.insr       = insr_q;
    assign bus.insr_valid = (state_q == ISSUE);
    assign bus.state      = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.trap       = (state_q == HALT);
`else
    assign bus.trap       = 1'b0;
`endif
endmodule

// File: tb/tb_insr_issue_ctrl.sv
// Bench for insr_issue_ctrl: directed vector table, multi-cycle corner sequences,
// then random traffic scored against a rule-level model of fetch/issue behaviour.
module tb_insr_issue_ctrl;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          MEM_TIMEOUT = 15;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [6:0] BASE_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                            7'b0100011, 7'b1100011, 7'b0110111,
                                            7'b0010111, 7'b1101111, 7'b1100111};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    insr_issue_ctrl_if bus();

    insr_issue_ctrl #(
        .RESET_PC    (RESET_PC),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_insr;
        logic [1:0]  e_state;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ack, input logic [31:0] data,
                         input logic rdy, input logic redir, input logic [31:0] rpc);
        rst             = r;
        bus.imem_ack    = ack;
        bus.imem_data   = data;
        bus.ex_ready    = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic e_req, input logic [31:0] e_pc,
                               input logic e_valid, input logic [31:0] e_insr,
                               input logic [1:0] e_state, input logic e_trap);
        chk({tag, ".req"},   32'(bus.imem_req),   32'(e_req));
        chk({tag, ".addr"},  bus.imem_addr,       e_pc);
        chk({tag, ".pc"},    bus.pc,              e_pc);
        chk({tag, ".valid"}, 32'(bus.insr_valid), 32'(e_valid));
        chk({tag, ".insr"},  bus.insr,            e_insr);
        chk({tag, ".state"}, 32'(bus.state),      32'(e_state));
        chk({tag, ".trap"},  32'(bus.trap),       32'(e_trap));
    endtask

    function automatic bit is_base_op(input logic [31:0] w);
        bit hit = 1'b0;
        for (int k = 0; k < 9; k++)
            if (w[6:0] == BASE_OPS[k]) hit = 1'b1;
        return hit;
    endfunction

    // Reference model: tracks whether a word is held, whether the core is halted,
    // and how many unanswered request cycles have elapsed in the current fetch.
    bit          m_hold, m_halt;
    int          m_idle;
    logic [31:0] m_pc, m_insr;

    function automatic bit m_req();
        return !m_hold && !m_halt && (m_idle != MEM_TIMEOUT);
    endfunction

    task automatic model_step(input logic r, input logic ack, input logic [31:0] data,
                              input logic rdy, input logic redir, input logic [31:0] rpc);
        bit req_now;
        req_now = m_req();
        if (r) begin
            m_pc = RESET_PC; m_hold = 0; m_halt = 0; m_insr = 32'h13; m_idle = 0;
        end else if (m_halt) begin
            m_halt = 1;
        end else if (redir) begin
            m_pc = {rpc[31:2], 2'b00}; m_hold = 0; m_idle = 0;
        end else if (m_hold) begin
            if (rdy) begin
                m_pc = m_pc + 32'd4; m_hold = 0; m_idle = 0;
            end
        end else if (req_now && ack) begin
            m_insr = data; m_idle = 0;
            if (TRAP_EN && !is_base_op(data)) m_halt = 1;
            else m_hold = 1;
        end else if (!req_now) begin
            m_idle = 0;
        end else begin
            m_idle = m_idle + 1;
        end
    endtask

    initial begin
        vecs[0]  = '{1, 1, 32'hDEADBEEF, 0, 0, 32'h0,   1, 32'h0,   0, 32'h13,       2'd0};
        vecs[1]  = '{1, 0, 32'h0,        0, 0, 32'h0,   1, 32'h0,   0, 32'h13,       2'd0};
        vecs[2]  = '{0, 0, 32'h0,        0, 0, 32'h0,   1, 32'h0,   0, 32'h13,       2'd0};
        vecs[3]  = '{0, 1, 32'h00500093, 1, 0, 32'h0,   0, 32'h0,   1, 32'h00500093, 2'd1};
        vecs[4]  = '{0, 0, 32'h0,        1, 0, 32'h0,   1, 32'h4,   0, 32'h00500093, 2'd0};
        vecs[5]  = '{0, 1, 32'h00A00113, 0, 0, 32'h0,   0, 32'h4,   1, 32'h00A00113, 2'd1};
        vecs[6]  = '{0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h4,   1, 32'h00A00113, 2'd1};
        vecs[7]  = '{0, 0, 32'h0,        1, 1, 32'h103, 1, 32'h100, 0, 32'h00A00113, 2'd0};
        vecs[8]  = '{0, 1, 32'h12345693, 0, 1, 32'h200, 1, 32'h200, 0, 32'h00A00113, 2'd0};
        vecs[9]  = '{0, 1, 32'h00000013, 0, 0, 32'h0,   0, 32'h200, 1, 32'h13,       2'd1};
        vecs[10] = '{0, 0, 32'h0,        1, 0, 32'h0,   1, 32'h204, 0, 32'h13,       2'd0};

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].ack, vecs[i].data, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
            expect_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc, vecs[i].e_valid,
                        vecs[i].e_insr, vecs[i].e_state, 1'b0);
        end

        // Stall in ISSUE for five cycles, then accept.
        drive(0, 1, 32'h00108093, 0, 0, 0);
        expect_outs("hold.enter", 0, 32'h204, 1, 32'h00108093, 2'd1, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 32'h0, 0, 0, 0);
            expect_outs($sformatf("hold%0d", i), 0, 32'h204, 1, 32'h00108093, 2'd1, 0);
        end
        drive(0, 0, 32'h0, 1, 0, 0);
        expect_outs("hold.accept", 1, 32'h208, 0, 32'h00108093, 2'd0, 0);

        // Unanswered fetch: fifteen request cycles, one gap, then resume at the same address.
        for (int i = 1; i <= 16; i++) begin
            drive(0, 0, 32'h0, 0, 0, 0);
            expect_outs($sformatf("tmo%0d", i), (i != MEM_TIMEOUT), 32'h208, 0, 32'h00108093, 2'd0, 0);
        end

        // Top-of-memory wrap.
        drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFE);
        expect_outs("wrap.redir", 1, 32'hFFFF_FFFC, 0, 32'h00108093, 2'd0, 0);
        drive(0, 1, 32'h00000013, 0, 0, 0);
        expect_outs("wrap.ack", 0, 32'hFFFF_FFFC, 1, 32'h13, 2'd1, 0);
        drive(0, 0, 32'h0, 1, 0, 0);
        expect_outs("wrap.accept", 1, 32'h0, 0, 32'h13, 2'd0, 0);

        // All-ones word: not a base opcode.
        drive(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        if (TRAP_EN) begin
            expect_outs("ill.halt", 0, 32'h0, 0, 32'hFFFF_FFFF, 2'd2, 1);
            drive(0, 0, 32'h0, 1, 1, 32'h40);
            expect_outs("ill.redir", 0, 32'h0, 0, 32'hFFFF_FFFF, 2'd2, 1);
            drive(0, 1, 32'h13, 1, 0, 0);
            expect_outs("ill.stay", 0, 32'h0, 0, 32'hFFFF_FFFF, 2'd2, 1);
            drive(1, 0, 32'h0, 0, 0, 0);
            expect_outs("ill.rst", 1, RESET_PC, 0, 32'h13, 2'd0, 0);
        end else begin
            expect_outs("ill.issue", 0, 32'h0, 1, 32'hFFFF_FFFF, 2'd1, 0);
            drive(0, 0, 32'h0, 1, 0, 0);
            expect_outs("ill.accept", 1, 32'h4, 0, 32'hFFFF_FFFF, 2'd0, 0);
            drive(1, 0, 32'h0, 0, 0, 0);
            expect_outs("ill.rst", 1, RESET_PC, 0, 32'h13, 2'd0, 0);
        end

        // Random traffic against the model.
        m_pc = RESET_PC; m_hold = 0; m_halt = 0; m_insr = 32'h13; m_idle = 0;
        for (int n = 0; n < 3000; n++) begin
            logic        r, ack, rdy, redir;
            logic [31:0] data, rpc, rw;
            r     = ($urandom_range(0, 39) == 0);
            ack   = ($urandom_range(0, 2) == 0);
            rdy   = $urandom_range(0, 1) == 1;
            redir = ($urandom_range(0, 7) == 0);
            rw    = $urandom();
            if ($urandom_range(0, 9) == 0) data = rw;
            else data = {rw[31:7], BASE_OPS[$urandom_range(0, 8)]};
            rw = $urandom();
            rpc = ($urandom_range(0, 3) == 0) ? {30'h3FFF_FFFF, rw[1:0]} : rw;
            model_step(r, ack, data, rdy, redir, rpc);
            drive(r, ack, data, rdy, redir, rpc);
            expect_outs("rnd", m_req(), m_pc, m_hold, m_insr,
                        m_halt ? 2'd2 : (m_hold ? 2'd1 : 2'd0), m_halt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
